// File: rtl/adc_spi_emulator.sv
// adc_spi_emulator
//   Emulates a SAR ADC serial output stage for bring-up of an SPI master.
//   Each nCS-low frame returns one sample of one channel, round-robin,
//   from one of four sources chosen by MODE when the frame starts.
//   Ports:
//     CLK, nRST             system clock, asynchronous active-low reset
//     nCS, SCLK             SPI pins from the master (asynchronous, oversampled)
//     MODE, CONST_VALUE     sample source select / constant sample
//     WR_EN, WR_CH, WR_DATA register-file write port
//     DOUT, DOUT_OE         serial data and its output enable
//     CHANNEL               channel of the current (or next) frame
//     FRAME_DONE, ABORT     one-cycle completion / abort pulses
module adc_spi_emulator #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int NUM_CHANNELS = 4,
  parameter int LEAD_ZEROS   = 1,
  parameter int TRAIL_ZEROS  = 2,
  parameter int INCREMENT    = 1,
  parameter int SAMPLE_HOLD  = 3,
  parameter int CH_OFFSET    = 256,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    nCS,
  input  logic                    SCLK,
  input  logic [1:0]              MODE,
  input  logic [SAMPLE_WIDTH-1:0] CONST_VALUE,
  input  logic                    WR_EN,
  input  logic [CH_W-1:0]         WR_CH,
  input  logic [SAMPLE_WIDTH-1:0] WR_DATA,
  output logic                    DOUT,
  output logic                    DOUT_OE,
  output logic [CH_W-1:0]         CHANNEL,
  output logic                    FRAME_DONE,
  output logic                    ABORT
);

  localparam int DATA_BITS  = LEAD_ZEROS + SAMPLE_WIDTH + TRAIL_ZEROS;
  localparam int FRAME_BITS = DATA_BITS + 1;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int HOLD_W     = $clog2(SAMPLE_HOLD + 1);
  localparam int LSB_CNT    = LEAD_ZEROS + SAMPLE_WIDTH - 1;

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, TAIL} state_e;

  // sync[0],[1] form the synchroniser; sync[2] is the edge-detect stage
  logic [2:0]              ncs_sync_q, ncs_sync_d;
  logic [2:0]              sclk_sync_q, sclk_sync_d;
  logic [1:0]              sync_vld_q, sync_vld_d;
  state_e                  state_q, state_d;
  logic [DATA_BITS-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dout_q, dout_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;
  logic                    toggle_q, toggle_d;
  logic [SAMPLE_WIDTH-1:0] ramp_q [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] ramp_d [NUM_CHANNELS];
  logic [HOLD_W-1:0]       hold_q [NUM_CHANNELS];
  logic [HOLD_W-1:0]       hold_d [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] regs_q [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] regs_d [NUM_CHANNELS];

  logic                    ncs_fall, ncs_rise, sclk_fall;
  logic [CNT_W-1:0]        cnt_inc, cnt_eff;
  logic [SAMPLE_WIDTH-1:0] sample_sel;
  logic [DATA_BITS-1:0]    frame_load;
  logic [HOLD_W-1:0]       hold_next;

  assign ncs_fall  =  ncs_sync_q[2]  & ~ncs_sync_q[1];
  assign ncs_rise  = ~ncs_sync_q[2]  &  ncs_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // an SCLK fall coinciding with nCS rise is counted before completion is judged
  assign cnt_eff   = (state_q == SHIFT && sclk_fall) ? cnt_inc : cnt_q;
  assign hold_next = hold_q[ch_q] + HOLD_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '1;
      sync_vld_q  <= '0;
      state_q     <= WAIT_HIGH;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dout_q      <= 1'b0;
      ch_q        <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      toggle_q    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        ramp_q[c] <= SAMPLE_WIDTH'(c * CH_OFFSET);
        hold_q[c] <= '0;
        regs_q[c] <= '0;
      end
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      sync_vld_q  <= sync_vld_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      ch_q        <= ch_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      toggle_q    <= toggle_d;
      ramp_q      <= ramp_d;
      hold_q      <= hold_d;
      regs_q      <= regs_d;
    end
  end

  // Next-state logic. The synchroniser holds reset values for two cycles, so
  // WAIT_HIGH only trusts nCS once sync_vld_q shows those stages are flushed;
  // otherwise a pin held low through reset would look like a fresh fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HIGH: if (sync_vld_q[1] && ncs_sync_q[1] && ncs_sync_q[2]) state_d = IDLE;
      IDLE:      if (ncs_fall) state_d = SHIFT;
      SHIFT: begin
        if (ncs_rise)                                          state_d = IDLE;
        else if (sclk_fall && cnt_inc == CNT_W'(DATA_BITS))    state_d = TAIL;
      end
      TAIL:      if (ncs_rise) state_d = IDLE;
      default:   state_d = WAIT_HIGH;
    endcase
  end

  always_comb begin
    sample_sel = '0;
    case (MODE)
      2'd0:    sample_sel = ramp_q[ch_q];
      2'd1:    sample_sel = CONST_VALUE;
      2'd2:    sample_sel = regs_q[ch_q];
      default: sample_sel = toggle_q ? '1 : '0;
    endcase
    // leading zeros come from zero-extension, trailing zeros from the shift
    frame_load = DATA_BITS'(sample_sel) << TRAIL_ZEROS;
  end

  // Datapath: shift register, edge counter, channel/ramp bookkeeping.
  always_comb begin
    ncs_sync_d  = {ncs_sync_q[1:0], nCS};
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    ch_d        = ch_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    toggle_d    = toggle_q;
    ramp_d      = ramp_q;
    hold_d      = hold_q;
    regs_d      = regs_q;

    if (WR_EN && (32'(WR_CH) < NUM_CHANNELS)) regs_d[WR_CH] = WR_DATA;

    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          dout_d  = frame_load[DATA_BITS-1];
          shreg_d = frame_load << 1;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DATA_BITS)) begin
            dout_d = 1'b0;
          end else begin
            dout_d  = shreg_q[DATA_BITS-1];
            shreg_d = shreg_q << 1;
          end
        end
      end
      default: ;
    endcase

    if ((state_q == SHIFT || state_q == TAIL) && ncs_rise) begin
      dout_d = 1'b0;
      if (cnt_eff >= CNT_W'(LSB_CNT)) begin
        done_d   = 1'b1;
        toggle_d = ~toggle_q;
        ch_d     = (ch_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
        if (hold_next == HOLD_W'(SAMPLE_HOLD)) begin
          hold_d[ch_q] = '0;
          ramp_d[ch_q] = ramp_q[ch_q] + SAMPLE_WIDTH'(INCREMENT);
        end else begin
          hold_d[ch_q] = hold_next;
        end
      end else begin
        abort_d = 1'b1;
      end
    end
  end

  // Output enable is decoded from state so reset removes it asynchronously.
  always_comb begin
    DOUT       = dout_q;
    DOUT_OE    = (state_q == SHIFT);
    CHANNEL    = ch_q;
    FRAME_DONE = done_q;
    ABORT      = abort_q;
  end

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Self-checking bench for adc_spi_emulator: a behavioural model predicts each
// frame's channel, sample and completion; predictions are queued when the
// frame is driven and compared once the frame has been shifted out.
module tb_adc_spi_emulator;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic        ncs_m, sclk_m, ncs_w, sclk_w;
  logic [1:0]  MODE;
  logic [11:0] CONST_VALUE;
  logic        WR_EN;
  logic [1:0]  WR_CH;
  logic [11:0] WR_DATA;
  logic        dout_m, oe_m, done_m, abort_m;
  logic [1:0]  ch_m;
  logic        dout_w, oe_w, done_w, abort_w;
  logic        ch_w;

  adc_spi_emulator u_dut (
    .CLK(CLK), .nRST(nRST), .nCS(ncs_m), .SCLK(sclk_m),
    .MODE(MODE), .CONST_VALUE(CONST_VALUE),
    .WR_EN(WR_EN), .WR_CH(WR_CH), .WR_DATA(WR_DATA),
    .DOUT(dout_m), .DOUT_OE(oe_m), .CHANNEL(ch_m),
    .FRAME_DONE(done_m), .ABORT(abort_m)
  );

  // second instance: two channels, ramp[1] starts at 0xFFF, steps every frame
  adc_spi_emulator #(
    .NUM_CHANNELS(2), .SAMPLE_HOLD(1), .INCREMENT(1), .CH_OFFSET(4095)
  ) u_wrap (
    .CLK(CLK), .nRST(nRST), .nCS(ncs_w), .SCLK(sclk_w),
    .MODE(2'd0), .CONST_VALUE(12'h000),
    .WR_EN(1'b0), .WR_CH(1'b0), .WR_DATA(12'h000),
    .DOUT(dout_w), .DOUT_OE(oe_w), .CHANNEL(ch_w),
    .FRAME_DONE(done_w), .ABORT(abort_w)
  );

  typedef struct {
    logic [11:0] sample;
    bit          done;
    logic [1:0]  ch;
    int          nf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fnum  = 0;

  // reference model, main instance
  logic [11:0] m_ramp [4];
  int          m_hold [4];
  logic [11:0] m_regs [4];
  logic [1:0]  m_ch;
  bit          m_tog;
  // reference model, wrap instance
  logic [11:0] w_ramp [2];
  bit          w_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ramp[c] = 12'(c * 256);
      m_hold[c] = 0;
      m_regs[c] = 12'h000;
    end
    m_ch   = 2'd0;
    m_tog  = 1'b0;
    w_ramp[0] = 12'h000;
    w_ramp[1] = 12'hFFF;
    w_ch   = 1'b0;
  endtask

  function automatic logic [11:0] m_sample();
    case (MODE)
      2'd0:    return m_ramp[m_ch];
      2'd1:    return CONST_VALUE;
      2'd2:    return m_regs[m_ch];
      default: return m_tog ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Master side of one frame: nCS low, nf SCLK falls, nCS high. DOUT/DOUT_OE
  // are sampled at the start and after every fall; pulses counted afterwards.
  task automatic spi_frame(input bit tgt, input int nf, input bit do_wr,
                           input logic [1:0] wch, input logic [11:0] wdat,
                           output logic [15:0] obs, output logic [15:0] oes,
                           output int nd, output int na, output logic [1:0] cho);
    obs = '0;
    oes = '0;
    cho = tgt ? {1'b0, ch_w} : ch_m;
    if (tgt) ncs_w = 1'b0; else ncs_m = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    if (do_wr) begin
      WR_EN = 1'b1; WR_CH = wch; WR_DATA = wdat;   // lands on the latch edge
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    @(negedge CLK);
    obs[0] = tgt ? dout_w : dout_m;
    oes[0] = tgt ? oe_w : oe_m;
    for (int i = 1; i <= nf; i++) begin
      if (tgt) sclk_w = 1'b0; else sclk_m = 1'b0;
      repeat (4) @(negedge CLK);
      obs[i] = tgt ? dout_w : dout_m;
      oes[i] = tgt ? oe_w : oe_m;
      if (tgt) sclk_w = 1'b1; else sclk_m = 1'b1;
      repeat (4) @(negedge CLK);
    end
    if (tgt) ncs_w = 1'b1; else ncs_m = 1'b1;
    nd = 0;
    na = 0;
    repeat (8) begin
      @(negedge CLK);
      nd += int'(tgt ? done_w : done_m);
      na += int'(tgt ? abort_w : abort_m);
    end
  endtask

  task automatic run(input bit tgt, input int nf, input bit do_wr,
                     input logic [1:0] wch, input logic [11:0] wdat);
    exp_t        e;
    logic [15:0] obs, oes, ew, mask;
    int          nd, na;
    logic [1:0]  cho;
    string       t;
    e.done = (nf >= 12);
    e.nf   = nf;
    if (tgt) begin
      e.ch = {1'b0, w_ch};
      e.sample = w_ramp[w_ch];
    end else begin
      e.ch = m_ch;
      e.sample = m_sample();
    end
    exp_q.push_back(e);
    if (do_wr) m_regs[wch] = wdat;
    if (e.done) begin
      if (tgt) begin
        w_ramp[w_ch] = w_ramp[w_ch] + 12'd1;
        w_ch = ~w_ch;
      end else begin
        m_hold[m_ch]++;
        if (m_hold[m_ch] == 3) begin
          m_hold[m_ch] = 0;
          m_ramp[m_ch] = m_ramp[m_ch] + 12'd1;
        end
        m_ch  = (m_ch == 2'd3) ? 2'd0 : m_ch + 2'd1;
        m_tog = ~m_tog;
      end
    end

    spi_frame(tgt, nf, do_wr, wch, wdat, obs, oes, nd, na, cho);

    e  = exp_q.pop_front();
    ew = '0;
    for (int k = 0; k < 12; k++) ew[1 + k] = e.sample[11 - k];
    mask = 16'((32'h1 << (e.nf + 1)) - 1);
    fnum++;
    t = $sformatf("frame%0d", fnum);
    check({t, ".chan"},  32'(cho), 32'(e.ch));
    check({t, ".word"},  32'(obs & mask), 32'(ew & mask));
    check({t, ".oe"},    32'(oes & mask), 32'(16'h7FFF & mask));
    check({t, ".done"},  32'(nd), 32'(e.done ? 1 : 0));
    check({t, ".abort"}, 32'(na), 32'(e.done ? 0 : 1));
  endtask

  task automatic reg_write(input logic [1:0] ch, input logic [11:0] d);
    @(negedge CLK);
    WR_EN = 1'b1; WR_CH = ch; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
    m_regs[ch] = d;
  endtask

  int nd_r, na_r;

  initial begin
    nRST = 1'b0;
    ncs_m = 1'b1; sclk_m = 1'b1; ncs_w = 1'b1; sclk_w = 1'b1;
    MODE = 2'd0; CONST_VALUE = 12'h000;
    WR_EN = 1'b0; WR_CH = 2'd0; WR_DATA = 12'h000;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset.dout",  32'(dout_m),  32'd0);
    check("reset.oe",    32'(oe_m),    32'd0);
    check("reset.chan",  32'(ch_m),    32'd0);
    check("reset.done",  32'(done_m),  32'd0);
    check("reset.abort", 32'(abort_m), 32'd0);
    nRST = 1'b1;
    repeat (6) @(negedge CLK);

    // ramp wrap: 0x000, 0xFFF, 0x001, 0x000
    repeat (4) run(1'b1, 13, 1'b0, 2'd0, 12'h0);

    // ramp mode, first frame runs into the hi-Z bit
    run(1'b0, 15, 1'b0, 2'd0, 12'h0);
    repeat (12) run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    // abort after 11 falls, retry, boundary completion after exactly 12
    run(1'b0, 11, 1'b0, 2'd0, 12'h0);
    run(1'b0, 12, 1'b0, 2'd0, 12'h0);
    run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    // register file source
    reg_write(2'd2, 12'hA5C);
    MODE = 2'd2;
    repeat (4) run(1'b0, 13, 1'b0, 2'd0, 12'h0);
    for (int g = 0; g < 4 && m_ch != 2'd2; g++) run(1'b0, 13, 1'b0, 2'd0, 12'h0);
    run(1'b0, 13, 1'b1, 2'd2, 12'h3C3);     // write collides with latch: old value
    repeat (4) run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    // constant source
    MODE = 2'd1; CONST_VALUE = 12'h123;
    repeat (3) run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    // full-scale toggle
    MODE = 2'd3;
    repeat (4) run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    // reset in the middle of a frame
    MODE = 2'd0;
    if (m_ch == 2'd0) run(1'b0, 13, 1'b0, 2'd0, 12'h0);
    ncs_m = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      sclk_m = 1'b0; repeat (4) @(negedge CLK);
      sclk_m = 1'b1; repeat (4) @(negedge CLK);
    end
    check("prerst.oe", 32'(oe_m), 32'd1);
    nRST = 1'b0;
    #1;
    check("midrst.oe",   32'(oe_m),   32'd0);
    check("midrst.chan", 32'(ch_m),   32'd0);
    check("midrst.dout", 32'(dout_m), 32'd0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    nd_r = 0; na_r = 0;
    for (int i = 0; i < 4; i++) begin
      sclk_m = 1'b0;
      repeat (4) begin
        @(negedge CLK);
        nd_r += int'(done_m);
        na_r += int'(abort_m);
      end
      check($sformatf("postrst.oe%0d", i), 32'(oe_m), 32'd0);
      sclk_m = 1'b1;
      repeat (4) @(negedge CLK);
    end
    ncs_m = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      nd_r += int'(done_m);
      na_r += int'(abort_m);
    end
    check("postrst.done",  32'(nd_r), 32'd0);
    check("postrst.abort", 32'(na_r), 32'd0);
    run(1'b0, 15, 1'b0, 2'd0, 12'h0);
    run(1'b0, 13, 1'b0, 2'd0, 12'h0);

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

endmodule
